reg_read_responder: RTL and testbench

Handshaked read-side responder for a bank of `register` storage elements. Writes arrive on a simple enable strobe, the same way `register` loads, and read requests arrive on a valid/ready channel. Each read is answered on a registered valid/ready response channel. A 2-entry response buffer provides full throughput and absorbs backpressure. Bus-facing logic uses this block to read CPU-visible registers without a combinational path from request to response.

---
 rtl/reg_read_responder.sv | 133 +++++++++++++
 tb/tb_reg_read_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_read_responder.sv
`timescale 1ns/1ps
// reg_read_responder
//   A bank of DEPTH x WIDTH registers. Writes land on a plain enable strobe.
//   Reads arrive on a valid/ready request channel and are answered from a
//   2-entry response FIFO on a valid/ready response channel. No request input
//   reaches a response output without passing through a flop.
//
// Ports
//   clk, rst             : single clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data: write strobe; out-of-range addresses are dropped
//   req_valid/req_ready  : read request handshake (req_ready is registered)
//   req_addr             : read address
//   rsp_valid/rsp_ready  : response handshake
//   rsp_data/rsp_err     : head-of-FIFO response; both zero when empty
module reg_read_responder #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 8,
  parameter int               ADDR_W      = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_err
);

  // One extra bit so DEPTH itself is representable for range compares.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  // Register bank
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Response FIFO: data/err slots carry no reset; count and pointers do.
  logic [WIDTH-1:0] fifo_data_q [2];
  logic             fifo_err_q  [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             req_ready_q, req_ready_d;

  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_hit;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] rd_data;
  logic             rd_err;

  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    rd_in_range = ({1'b0, req_addr} < DEPTH_W);
    wr_hit      = wr_en && wr_in_range;
    push        = req_valid && req_ready_q;
    pop         = (count_q != 2'd0) && rsp_ready;

    // Snapshot taken at acceptance; a same-edge write to the same address
    // wins so the response reflects the post-edge register contents.
    rd_data = '0;
    rd_err  = 1'b0;
    if (!rd_in_range) begin
      rd_err = 1'b1;
    end else if (wr_hit && (wr_addr == req_addr)) begin
      rd_data = wr_data;
    end else begin
      rd_data = mem_q[req_addr];
    end

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;

    // Ready drops as soon as the buffer will be full, so a push never
    // lands on a full FIFO.
    req_ready_d = (count_d != 2'd2);
  end

  // Register bank update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_VALUE;
      end
    end else if (wr_hit) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // FIFO control
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      req_ready_q <= req_ready_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_data_q[wr_ptr_q] <= rd_data;
      fifo_err_q[wr_ptr_q]  <= rd_err;
    end
  end

  // Empty FIFO presents zeros so stale slot contents never leak out.
  always_comb begin
    req_ready = req_ready_q;
    rsp_valid = (count_q != 2'd0);
    rsp_data  = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
    rsp_err   = rsp_valid ? fifo_err_q[rd_ptr_q]  : 1'b0;
  end

endmodule

// File: tb/tb_reg_read_responder.sv
`timescale 1ns/1ps
module tb_reg_read_responder;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 6;
  localparam int         AW    = 3;
  localparam logic [7:0] RV    = 8'h5A;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [7:0]    rsp_data;
  logic          rsp_err;

  reg_read_responder #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Reference model: register array plus an in-order queue of responses.
  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } rsp_t;

  logic [7:0] mem_m [DEPTH];
  rsp_t       q_m [$];
  logic       ready_m = 1'b0;
  int         n_pop   = 0;
  int         n_acc   = 0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, update the model with the inputs that were present
  // at the edge, then compare every output against the model.
  task automatic cycle();
    bit   acc;
    bit   pp;
    rsp_t r;
    acc = !rst && req_valid && ready_m;
    pp  = !rst && (q_m.size() != 0) && rsp_ready;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_m[i] = RV;
      q_m.delete();
      ready_m = 1'b0;
    end else begin
      if (pp) begin
        void'(q_m.pop_front());
        n_pop++;
      end
      if (acc) begin
        n_acc++;
        if (int'(req_addr) >= DEPTH) begin
          r.d = 8'h00; r.e = 1'b1;
        end else if (wr_en && wr_addr == req_addr) begin
          r.d = wr_data; r.e = 1'b0;
        end else begin
          r.d = mem_m[req_addr]; r.e = 1'b0;
        end
        q_m.push_back(r);
      end
      if (wr_en && int'(wr_addr) < DEPTH) mem_m[wr_addr] = wr_data;
      ready_m = (q_m.size() < 2);
    end
    check("rsp_valid", 32'(rsp_valid), 32'(q_m.size() != 0));
    check("req_ready", 32'(req_ready), 32'(ready_m));
    check("rsp_data",  32'(rsp_data),  (q_m.size() != 0) ? 32'(q_m[0].d) : 32'd0);
    check("rsp_err",   32'(rsp_err),   (q_m.size() != 0) ? 32'(q_m[0].e) : 32'd0);
  endtask

  task automatic idle();
    wr_en = 1'b0; req_valid = 1'b0;
  endtask

  initial begin
    int p0;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;

    // Reset with a request presented: must not be accepted
    req_valid = 1'b1; req_addr = 3'd1;
    cycle();
    cycle();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);

    // Release: ready one edge later
    rst = 1'b0; req_valid = 1'b0;
    cycle();
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // Read addr 3 after reset: 1-cycle latency, reset value
    req_valid = 1'b1; req_addr = 3'd3;
    cycle();
    check("rd3_valid", 32'(rsp_valid), 32'd1);
    check("rd3_data",  32'(rsp_data),  32'h5A);
    check("rd3_err",   32'(rsp_err),   32'd0);
    idle();
    cycle();

    // Write then read
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hC3;
    cycle();
    idle(); req_valid = 1'b1; req_addr = 3'd2;
    cycle();
    check("wr_rd2_data", 32'(rsp_data), 32'hC3);

    // Same-edge write and read of addr 5
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h11; req_valid = 1'b1; req_addr = 3'd5;
    cycle();
    check("bypass_data", 32'(rsp_data), 32'h11);
    idle();
    cycle();

    // Distinct contents for the backpressure run
    wr_en = 1'b1;
    for (int a = 0; a < 3; a++) begin
      wr_addr = AW'(a); wr_data = 8'hA0 + 8'(a);
      cycle();
    end
    idle();

    // Backpressure: 0 and 1 accepted, 2 held off
    rsp_ready = 1'b0; req_valid = 1'b1;
    req_addr = 3'd0; cycle();
    req_addr = 3'd1; cycle();
    check("bp_ready_low", 32'(req_ready), 32'd0);
    req_addr = 3'd2; cycle();
    check("bp_still_low", 32'(req_ready), 32'd0);
    // Rewrite addr 0 while its response sits stalled
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hEE;
    cycle();
    check("bp_stable_data", 32'(rsp_data), 32'hA0);
    wr_en = 1'b0; rsp_ready = 1'b1;
    cycle();
    check("bp_pop1_head",  32'(rsp_data),  32'hA1);
    check("bp_pop1_ready", 32'(req_ready), 32'd1);
    cycle();
    check("bp_head2", 32'(rsp_data), 32'hA2);
    idle();
    cycle();
    check("bp_drained", 32'(rsp_valid), 32'd0);

    // Streaming: 16 back-to-back requests over addrs 0..7
    p0 = n_pop;
    rsp_ready = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_addr = AW'(i % 8);
      cycle();
      check("stream_ready", 32'(req_ready), 32'd1);
      check("stream_valid", 32'(rsp_valid), 32'd1);
    end
    idle();
    cycle();
    check("stream_count", 32'(n_pop - p0), 32'd16);

    // Out-of-range read and write
    req_valid = 1'b1; req_addr = 3'd7;
    cycle();
    check("oor_err",  32'(rsp_err),  32'd1);
    check("oor_data", 32'(rsp_data), 32'd0);
    idle(); wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'hFF;
    cycle();
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      req_valid = 1'b1; req_addr = AW'(a);
      cycle();
    end
    idle();
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      wr_en     = $urandom_range(0, 1) == 1;
      wr_addr   = AW'($urandom_range(0, 7));
      wr_data   = 8'($urandom);
      req_valid = $urandom_range(0, 3) != 0;
      req_addr  = ($urandom_range(0, 1) == 1) ? wr_addr : AW'($urandom_range(0, 7));
      rsp_ready = $urandom_range(0, 2) != 0;
      cycle();
    end

    // Drain, then mid-operation reset with a full buffer
    rst = 1'b0; idle(); rsp_ready = 1'b1;
    repeat (3) cycle();
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h77;
    cycle();
    wr_en = 1'b0; rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 3'd4;
    repeat (3) cycle();
    check("full_valid", 32'(rsp_valid), 32'd1);
    check("full_ready", 32'(req_ready), 32'd0);
    check("full_head",  32'(rsp_data),  32'h77);
    rst = 1'b1;
    cycle();
    check("midrst_valid", 32'(rsp_valid), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    cycle();
    check("no_stale", 32'(rsp_valid), 32'd0);
    req_valid = 1'b1; req_addr = 3'd4;
    cycle();
    check("reload_data", 32'(rsp_data), 32'h5A);
    idle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
